// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and helpers for the four-digit seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS   = 4;
  localparam int BCD_W        = 4;
  localparam int SHOW_NUM_W   = 6;
  localparam int SHOW_DIGIT_W = 4;

  // One complete display image: four BCD nibbles plus one decimal point per digit.
  typedef struct packed {
    logic [NUM_DIGITS*BCD_W-1:0] bcd;
    logic [NUM_DIGITS-1:0]       dp;
  } disp_word_t;

  // Decoder code layout: {dp, reserved zero, bcd nibble}.
  function automatic logic [SHOW_NUM_W-1:0] pack_show_num(input logic dp,
                                                           input logic [BCD_W-1:0] bcd);
    return {dp, 1'b0, bcd};
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake bundle: producer offers a display image, controller accepts it.
interface seg_scan_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );
endinterface

// File: rtl/seg_scan_ctrl_prescaler.sv
// Free-running divider that marks the last cycle of each SCAN_DIV-cycle slot.
module scan_prescaler #(
  parameter int SCAN_DIV = 4096
) (
  input  logic clk,
  input  logic rst_n,
  output logic tc
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tc = (count == LAST);

  // Count 0..SCAN_DIV-1 and wrap on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit scan controller: double-buffered load, frame-aligned commit,
// and a registered digit/code output for the seven-segment decoder.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int                    SCAN_DIV   = 4096,
  parameter logic [SHOW_NUM_W-1:0] BLANK_CODE = 6'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_scan_ctrl_if.slave          load,
  input  logic                    blank_en,
  output logic [SHOW_DIGIT_W-1:0] show_digit,
  output logic [SHOW_NUM_W-1:0]   show_num,
  output logic                    frame_done
);

  logic       tc;
  logic [1:0] idx;
  logic [1:0] idx_next;
  logic       frame_end;

  disp_word_t active;
  disp_word_t active_next;
  disp_word_t shadow;
  logic       pending;
  logic       accept;
  logic       commit;

  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tc   (tc)
  );

  assign idx_next  = tc ? idx + 2'd1 : idx;
  assign frame_end = tc && (idx == 2'd3);

  // The shadow slot is free whenever nothing is waiting for a frame boundary,
  // so accept and commit are mutually exclusive by construction.
  assign load.load_ready = !pending;
  assign accept          = load.load_valid && !pending;
  assign commit          = frame_end && pending;

  // Forward the committing image so the digit 0 slot shows it immediately.
  assign active_next = commit ? shadow : active;

  // Digit index advances once per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else begin
      idx <= idx_next;
    end
  end

  // Shadow capture on accept, swap into the active image at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (accept) begin
        shadow  <= '{bcd: load.load_data, dp: load.load_dp};
        pending <= 1'b1;
      end
      if (commit) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end

  // Registered decoder drive, aligned with the slot the index is entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      show_digit <= '0;
      show_num   <= BLANK_CODE;
      frame_done <= 1'b0;
    end else begin
      show_digit <= {2'b00, idx_next};
      show_num   <= blank_en ? BLANK_CODE
                             : pack_show_num(active_next.dp[idx_next],
                                             active_next.bcd[{idx_next, 2'b00} +: BCD_W]);
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan period.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       blank_en;
  logic [3:0] show_digit;
  logic [5:0] show_num;
  logic       frame_done;

  int checks;
  int errors;
  int cyc;

  seg_scan_ctrl_if lif ();

  seg_scan_ctrl #(
    .SCAN_DIV  (4),
    .BLANK_CODE(6'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (lif),
    .blank_en  (blank_en),
    .show_digit(show_digit),
    .show_num  (show_num),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    blank_en       = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = 16'h0;
    lif.load_dp    = 4'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit", 32'(show_digit), 32'd0);
    check("rst_num",   32'(show_num),   32'd0);
    check("rst_frame", 32'(frame_done), 32'd0);
    check("rst_ready", 32'(lif.load_ready), 32'd1);
    rst_n = 1'b1;
    cyc   = 0;

    // Idle scan: four cycles per digit, frame pulse every 16
    for (int c = 1; c <= 32; c++) begin
      tick();
      check("idle_digit", 32'(show_digit), 32'((c / 4) % 4));
      check("idle_num",   32'(show_num),   32'd0);
      check("idle_frame", 32'(frame_done), (c % 16 == 0) ? 32'd1 : 32'd0);
    end

    // Single load mid-frame
    run_to(37);
    check("l1_ready_before", 32'(lif.load_ready), 32'd1);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1234;
    lif.load_dp    = 4'b0010;
    tick();
    lif.load_valid = 1'b0;
    lif.load_data  = 16'hDEAD;
    lif.load_dp    = 4'b1111;
    check("l1_ready_drop", 32'(lif.load_ready), 32'd0);
    run_to(47);
    check("l1_ready_hold", 32'(lif.load_ready), 32'd0);
    check("l1_old_d3",     32'(show_num),       32'h00);
    run_to(48);
    check("l1_d0_digit", 32'(show_digit), 32'd0);
    check("l1_d0_num",   32'(show_num),   32'h04);
    check("l1_ready_up", 32'(lif.load_ready), 32'd1);
    check("l1_frame",    32'(frame_done), 32'd1);
    run_to(52);
    check("l1_d1_num", 32'(show_num), 32'h23);
    run_to(56);
    check("l1_d2_num", 32'(show_num), 32'h02);
    run_to(60);
    check("l1_d3_digit", 32'(show_digit), 32'd3);
    check("l1_d3_num",   32'(show_num),   32'h01);

    // Back-to-back loads: second waits for the commit
    run_to(66);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1111;
    lif.load_dp    = 4'b0000;
    tick();
    check("b2b_ready_drop", 32'(lif.load_ready), 32'd0);
    lif.load_data = 16'h2222;
    run_to(79);
    check("b2b_ready_held", 32'(lif.load_ready), 32'd0);
    run_to(80);
    check("b2b_first_d0",   32'(show_num),       32'h01);
    check("b2b_ready_free", 32'(lif.load_ready), 32'd1);
    tick();
    check("b2b_second_acc", 32'(lif.load_ready), 32'd0);
    lif.load_valid = 1'b0;
    run_to(92);
    check("b2b_first_d3", 32'(show_num), 32'h01);
    run_to(96);
    check("b2b_second_d0", 32'(show_num),   32'h02);
    check("b2b_frame",     32'(frame_done), 32'd1);
    run_to(100);
    check("b2b_second_d1", 32'(show_num), 32'h02);

    // Blanking window with a commit inside it
    run_to(101);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h5678;
    lif.load_dp    = 4'b1000;
    tick();
    lif.load_valid = 1'b0;
    check("blk_ready_drop", 32'(lif.load_ready), 32'd0);
    tick();
    check("blk_pre_num", 32'(show_num), 32'h02);
    blank_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("blk_num",   32'(show_num),   32'd0);
      check("blk_digit", 32'(show_digit), 32'((cyc / 4) % 4));
    end
    check("blk_ready_commit", 32'(lif.load_ready), 32'd1);
    blank_en = 1'b0;
    tick();
    check("blk_post_d0", 32'(show_num), 32'h08);
    run_to(120);
    check("blk_post_d2", 32'(show_num), 32'h06);
    run_to(124);
    check("blk_post_d3", 32'(show_num), 32'h25);

    // Out-of-range nibble passes through
    run_to(130);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'hF000;
    lif.load_dp    = 4'b0000;
    tick();
    lif.load_valid = 1'b0;
    run_to(144);
    check("f_d0", 32'(show_num), 32'h00);

    // Queue a load that reset must discard
    run_to(150);
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h9999;
    lif.load_dp    = 4'b1111;
    tick();
    lif.load_valid = 1'b0;
    check("rp_ready_drop", 32'(lif.load_ready), 32'd0);
    run_to(156);
    check("f_d3_digit", 32'(show_digit), 32'd3);
    check("f_d3_num",   32'(show_num),   32'h0F);
    run_to(157);

    // Asynchronous reset mid-frame with a pending load
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_digit", 32'(show_digit), 32'd0);
    check("ar_num",   32'(show_num),   32'd0);
    check("ar_frame", 32'(frame_done), 32'd0);
    check("ar_ready", 32'(lif.load_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("ar_hold_num", 32'(show_num), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      check("ar_post_num",   32'(show_num),       32'd0);
      check("ar_post_ready", 32'(lif.load_ready), 32'd1);
      check("ar_post_digit", 32'(show_digit),     32'((c / 4) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
